// File: rtl/des_pkg.sv
// Shared DES constants: key/subkey widths, PC-1/PC-2 tables, the key-schedule shift table
// and the permutation/rotation helpers used by the key schedule and the S-box datapath.
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 56;
    localparam int HALF_W   = 28;
    localparam int SUBKEY_W = 48;
    localparam int ROUNDS   = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ks_state_e;

    // Entries are 1-based DES bit numbers; DES bit 1 is the vector MSB.
    localparam logic [5:0] PC1_TABLE [0:55] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
        6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
        6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
        6'd60, 6'd52, 6'd44, 6'd36, 6'd63, 6'd55, 6'd47, 6'd39,
        6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38,
        6'd30, 6'd22, 6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37,
        6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [5:0] PC2_TABLE [0:47] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
        6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
        6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
        6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
        6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    localparam logic [1:0] SHIFT_TABLE [0:15] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    function automatic logic [55:0] pc1(input logic [63:0] key);
        logic [55:0] res;
        logic [6:0]  src;
        res = 56'd0;
        for (int i = 0; i < 56; i++) begin
            src = 7'd64 - {1'b0, PC1_TABLE[6'(i)]};
            res[6'(55 - i)] = key[src[5:0]];
        end
        return res;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] res;
        logic [5:0]  src;
        res = 48'd0;
        for (int i = 0; i < 48; i++) begin
            src = 6'd56 - PC2_TABLE[6'(i)];
            res[6'(47 - i)] = cd[src];
        end
        return res;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[26:0], x[27]};
            2'd2:    return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        case (n)
            2'd1:    return {x[0], x[27:1]};
            2'd2:    return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 selection: 56-bit C||D register pair to 48-bit round subkey.
module des_pc2
    import des_pkg::*;
(
    input  logic [CD_W-1:0]     cd_i,
    output logic [SUBKEY_W-1:0] subkey_o
);

    // Pure bit selection, no logic levels.
    always_comb begin
        subkey_o = pc2(cd_i);
    end

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: one start handshake yields 16 subkeys over a valid/ready stream,
// in encrypt order (left rotations) or decrypt order (right rotations from C0/D0).
module des_key_schedule
    import des_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_W-1:0]    key_i,
    input  logic                decrypt_i,
    input  logic                start_valid_i,
    output logic                start_ready_o,
    output logic [SUBKEY_W-1:0] subkey_o,
    output logic                subkey_valid_o,
    input  logic                subkey_ready_i,
    output logic [3:0]          round_o,
    output logic                last_o
);

    ks_state_e         state_q, state_d;
    logic [HALF_W-1:0] c_q, c_d;
    logic [HALF_W-1:0] d_q, d_d;
    logic [3:0]        round_q, round_d;
    logic              dec_q, dec_d;
    logic [CD_W-1:0]   cd_load;
    logic [1:0]        enc_shift;
    logic [1:0]        dec_shift;

    // Next-state logic: load and first rotation on start, per-transfer rotation in RUN.
    always_comb begin
        state_d   = state_q;
        c_d       = c_q;
        d_d       = d_q;
        round_d   = round_q;
        dec_d     = dec_q;
        cd_load   = pc1(key_i);
        // Decrypt walks back from C16=C0, undoing DES round 17-(round+1).
        enc_shift = SHIFT_TABLE[round_q + 4'd1];
        dec_shift = SHIFT_TABLE[4'd15 - round_q];
        case (state_q)
            ST_IDLE: begin
                if (start_valid_i) begin
                    dec_d   = decrypt_i;
                    round_d = 4'd0;
                    state_d = ST_RUN;
                    if (decrypt_i) begin
                        c_d = cd_load[55:28];
                        d_d = cd_load[27:0];
                    end else begin
                        c_d = rotl28(cd_load[55:28], 2'd1);
                        d_d = rotl28(cd_load[27:0], 2'd1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (subkey_ready_i) begin
                    if (round_q == 4'd15) begin
                        state_d = ST_IDLE;
                        round_d = 4'd0;
                    end else if (dec_q) begin
                        round_d = round_q + 4'd1;
                        c_d     = rotr28(c_q, dec_shift);
                        d_d     = rotr28(d_q, dec_shift);
                    end else begin
                        round_d = round_q + 4'd1;
                        c_d     = rotl28(c_q, enc_shift);
                        d_d     = rotl28(d_q, enc_shift);
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                round_d = 4'd0;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over any handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            c_q     <= 28'd0;
            d_q     <= 28'd0;
            round_q <= 4'd0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            dec_q   <= dec_d;
        end
    end

    des_pc2 u_pc2 (
        .cd_i     ({c_q, d_q}),
        .subkey_o (subkey_o)
    );

    assign start_ready_o  = (state_q == ST_IDLE);
    assign subkey_valid_o = (state_q == ST_RUN);
    assign round_o        = round_q;
    assign last_o         = (state_q == ST_RUN) && (round_q == 4'd15);

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: random keys/backpressure checked against a reference that
// builds each subkey from cumulative left rotations of PC-1(key), reversed for decrypt.
module tb_des_key_schedule;

    logic        clk;
    logic        rst;
    logic [63:0] key_i;
    logic        decrypt_i;
    logic        start_valid_i;
    logic        start_ready_o;
    logic [47:0] subkey_o;
    logic        subkey_valid_o;
    logic        subkey_ready_i;
    logic [3:0]  round_o;
    logic        last_o;

    int checks = 0;
    int errors = 0;

    logic [47:0] exp_k [16];

    int PC1_T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                       60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                       29,21,13,5,28,20,12,4};
    int PC2_T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                       41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
    int SH_T  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    des_key_schedule dut (
        .clk            (clk),
        .rst            (rst),
        .key_i          (key_i),
        .decrypt_i      (decrypt_i),
        .start_valid_i  (start_valid_i),
        .start_ready_o  (start_ready_o),
        .subkey_o       (subkey_o),
        .subkey_valid_o (subkey_valid_o),
        .subkey_ready_i (subkey_ready_i),
        .round_o        (round_o),
        .last_o         (last_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Textbook schedule: Ki = PC2(C0,D0 rotated left by the running sum of shifts).
    task automatic build_exp(input logic [63:0] key, input logic dec);
        logic [55:0] cd;
        logic [27:0] c, d;
        logic [47:0] k;
        for (int i = 0; i < 56; i++) cd[55 - i] = key[64 - PC1_T[i]];
        c = cd[55:28];
        d = cd[27:0];
        for (int r = 0; r < 16; r++) begin
            for (int s = 0; s < SH_T[r]; s++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int j = 0; j < 48; j++) k[47 - j] = cd[56 - PC2_T[j]];
            if (dec) exp_k[15 - r] = k;
            else     exp_k[r] = k;
        end
    endtask

    // Entered and left on a falling edge. bp: 0 = ready held high, 1 = random with one 10-cycle stall.
    task automatic run_sched(input logic [63:0] key, input logic [63:0] model_key, input logic dec,
                             input int bp, input int rst_at, input bit poke,
                             input bit known, input logic [47:0] k_first, input logic [47:0] k_last);
        int  idx;
        int  cyc;
        int  stall;
        bit  did_long;
        build_exp(model_key, dec);
        chk("start_ready_idle", {63'd0, start_ready_o}, 64'd1);
        start_valid_i = 1'b1;
        key_i         = key;
        decrypt_i     = dec;
        subkey_ready_i = 1'b0;
        @(negedge clk);
        start_valid_i = 1'b0;
        key_i         = {$urandom(), $urandom()};
        decrypt_i     = 1'($urandom_range(0, 1));
        idx = 0; cyc = 0; stall = 0; did_long = 1'b0;
        while (idx < 16 && cyc < 3000) begin
            chk("subkey_valid", {63'd0, subkey_valid_o}, 64'd1);
            chk("start_ready_run", {63'd0, start_ready_o}, 64'd0);
            chk($sformatf("subkey[%0d]", idx), {16'd0, subkey_o}, {16'd0, exp_k[idx]});
            chk("round", {60'd0, round_o}, 64'(idx));
            chk("last", {63'd0, last_o}, (idx == 15) ? 64'd1 : 64'd0);
            if (known && idx == 0)  chk("known_first", {16'd0, subkey_o}, {16'd0, k_first});
            if (known && idx == 15) chk("known_last", {16'd0, subkey_o}, {16'd0, k_last});
            if (rst_at == idx) begin
                rst = 1'b1;
                subkey_ready_i = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                subkey_ready_i = 1'b0;
                chk("rst_valid", {63'd0, subkey_valid_o}, 64'd0);
                chk("rst_ready", {63'd0, start_ready_o}, 64'd1);
                chk("rst_round", {60'd0, round_o}, 64'd0);
                chk("rst_last", {63'd0, last_o}, 64'd0);
                chk("rst_subkey", {16'd0, subkey_o}, 64'd0);
                return;
            end
            if (bp == 0) begin
                subkey_ready_i = 1'b1;
            end else if (stall > 0) begin
                subkey_ready_i = 1'b0;
                stall--;
            end else if (idx == 5 && !did_long) begin
                subkey_ready_i = 1'b0;
                stall = 9;
                did_long = 1'b1;
            end else begin
                subkey_ready_i = 1'($urandom_range(0, 1));
            end
            if (poke) begin
                start_valid_i = 1'($urandom_range(0, 1));
                key_i         = {$urandom(), $urandom()};
                decrypt_i     = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            cyc++;
            if (subkey_ready_i) idx++;
        end
        start_valid_i  = 1'b0;
        subkey_ready_i = 1'b0;
        chk("sched_done", 64'(idx), 64'd16);
        chk("end_ready", {63'd0, start_ready_o}, 64'd1);
        chk("end_valid", {63'd0, subkey_valid_o}, 64'd0);
        chk("end_last", {63'd0, last_o}, 64'd0);
    endtask

    initial begin
        logic [63:0] rk;
        rst            = 1'b1;
        key_i          = 64'h0123456789ABCDEF;
        decrypt_i      = 1'b1;
        start_valid_i  = 1'b1;
        subkey_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {63'd0, start_ready_o}, 64'd1);
        chk("reset_valid", {63'd0, subkey_valid_o}, 64'd0);
        chk("reset_subkey", {16'd0, subkey_o}, 64'd0);
        chk("reset_round", {60'd0, round_o}, 64'd0);
        chk("reset_last", {63'd0, last_o}, 64'd0);
        rst           = 1'b0;
        start_valid_i = 1'b0;

        run_sched(64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 1'b0, 0, -1, 1'b0,
                  1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5);
        run_sched(64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 1'b1, 0, -1, 1'b0,
                  1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072);
        run_sched(64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 1'b0, 1, -1, 1'b0,
                  1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5);

        rk = {$urandom(), $urandom()};
        run_sched(rk, rk, 1'b0, 1, -1, 1'b1, 1'b0, 48'd0, 48'd0);
        rk = {$urandom(), $urandom()};
        run_sched(rk, rk, 1'b1, 1, -1, 1'b1, 1'b0, 48'd0, 48'd0);

        rk = {$urandom(), $urandom()};
        run_sched(rk, rk, 1'b0, 1, 7, 1'b0, 1'b0, 48'd0, 48'd0);
        run_sched(64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 1'b0, 0, -1, 1'b0,
                  1'b1, 48'h1B02EFFC7072, 48'hCB3D8B0E17F5);
        rk = {$urandom(), $urandom()};
        run_sched(rk, rk, 1'b1, 0, 7, 1'b0, 1'b0, 48'd0, 48'd0);
        run_sched(64'h133457799BBCDFF1, 64'h133457799BBCDFF1, 1'b1, 1, -1, 1'b0,
                  1'b1, 48'hCB3D8B0E17F5, 48'h1B02EFFC7072);

        run_sched(64'h0101010101010101, 64'h0000000000000000, 1'b0, 0, -1, 1'b0, 1'b0, 48'd0, 48'd0);
        rk = {$urandom(), $urandom()};
        run_sched(rk ^ 64'h0101010101010101, rk, 1'b1, 1, -1, 1'b0, 1'b0, 48'd0, 48'd0);

        for (int t = 0; t < 6; t++) begin
            rk = {$urandom(), $urandom()};
            run_sched(rk, rk, 1'(t % 2), 1, -1, 1'(t / 3), 1'b0, 48'd0, 48'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
